// File: rtl/echo_sequenciador_if.sv
// Control/data bundle between the echo sequencer and its driver.
// The master drives the strobes and code; the slave returns the echoed code and status.
interface echo_sequenciador_if #(
  parameter int CW = 3
);
  logic          load;
  logic [4:0]    code_in;
  logic          play;
  logic          clear;
  logic          S1;
  logic          S2;
  logic          S3;
  logic          S4;
  logic          S5;
  logic          busy;
  logic          full;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output load, code_in, play, clear,
    input  S1, S2, S3, S4, S5, busy, full, done, count
  );

  modport slave (
    input  load, code_in, play, clear,
    output S1, S2, S3, S4, S5, busy, full, done, count
  );
endinterface

// File: rtl/echo_sequenciador.sv
// Stores up to DEPTH 5-bit character codes and replays them, each held HOLD cycles
// with GAP blank cycles in between, feeding echo_display on S1..S5.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | blank output; accepts load / play / clear
// ST_SHOW | drives buf[idx] until the hold timer expires
// ST_GAP  | drives BLANK_CODE between two codes
module echo_sequenciador #(
  parameter int         DEPTH      = 4,
  parameter int         HOLD       = 50000000,
  parameter int         GAP        = 5000000,
  parameter logic [4:0] BLANK_CODE = 5'b00000
) (
  input logic          clk,
  input logic          rst_n,
  echo_sequenciador_if.slave bus
);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(DEPTH);
  localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tmr_q;
  logic [4:0]    code_q;
  logic          busy_q;
  logic          done_q;
  logic [4:0]    buf_q [DEPTH];

  logic full;
  logic last;
  logic buf_we;

  assign full   = (count_q == CW'(DEPTH));
  assign last   = (CW'(idx_q) == count_q - CW'(1));
  assign buf_we = (state_q == ST_IDLE) && bus.load && !bus.play && !bus.clear && !full;

  // Storage carries no reset: stale entries beyond count are never shown.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[IW'(count_q)] <= bus.code_in;
  end

  // Phase timer counts down from its load value; expiry is tmr_q == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      code_q  <= BLANK_CODE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.clear) begin
            count_q <= '0;
          end else if (bus.play) begin
            if (count_q != '0) begin
              idx_q   <= '0;
              tmr_q   <= HOLD_LD;
              code_q  <= buf_q[0];
              busy_q  <= 1'b1;
              state_q <= ST_SHOW;
            end
          end else if (buf_we) begin
            count_q <= count_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (bus.clear) begin
            count_q <= '0;
            code_q  <= BLANK_CODE;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
          end else if (last) begin
            code_q  <= BLANK_CODE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (GAP > 0) begin
            tmr_q   <= GAP_LD;
            code_q  <= BLANK_CODE;
            state_q <= ST_GAP;
          end else begin
            idx_q  <= idx_q + IW'(1);
            tmr_q  <= HOLD_LD;
            code_q <= buf_q[idx_q + IW'(1)];
          end
        end
        ST_GAP: begin
          if (bus.clear) begin
            count_q <= '0;
            code_q  <= BLANK_CODE;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
          end else begin
            idx_q   <= idx_q + IW'(1);
            tmr_q   <= HOLD_LD;
            code_q  <= buf_q[idx_q + IW'(1)];
            state_q <= ST_SHOW;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.S1    = code_q[4];
  assign bus.S2    = code_q[3];
  assign bus.S3    = code_q[2];
  assign bus.S4    = code_q[1];
  assign bus.S5    = code_q[0];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.full  = full;
  assign bus.count = count_q;
endmodule

// File: tb/tb_echo_sequenciador.sv
// Bench for echo_sequenciador: one instance with GAP=1 and one with GAP=0, HOLD=3, DEPTH=4.
module tb_echo_sequenciador;
  localparam int HOLD  = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld, pl, cl;
  logic [4:0] cd;
  logic       sel;

  always #5 clk = ~clk;

  echo_sequenciador_if #(.CW(CW)) if_g ();
  echo_sequenciador_if #(.CW(CW)) if_z ();

  assign if_g.load    = ld & ~sel;
  assign if_g.play    = pl & ~sel;
  assign if_g.clear   = cl & ~sel;
  assign if_g.code_in = cd;
  assign if_z.load    = ld & sel;
  assign if_z.play    = pl & sel;
  assign if_z.clear   = cl & sel;
  assign if_z.code_in = cd;

  echo_sequenciador #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(1), .BLANK_CODE(5'b00000)) dut_g (
    .clk(clk), .rst_n(rst_n), .bus(if_g));
  echo_sequenciador #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(0), .BLANK_CODE(5'b00000)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(if_z));

  typedef struct packed {
    logic [4:0]    s;
    logic          busy;
    logic          done;
    logic          full;
    logic [CW-1:0] count;
  } obs_t;

  typedef struct {
    logic       ld;
    logic [4:0] cd;
    logic       pl;
    logic       cl;
    int         count;
    int         full;
    int         busy;
    int         done;
    int         s;
  } vec_t;

  typedef struct {
    logic [4:0] s;
    logic       busy;
    logic       done;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  exp_t       exp_q[$];
  logic [4:0] codes[4];
  vec_t       vecs[8];

  function automatic obs_t get_obs();
    obs_t o;
    if (!sel) begin
      o.s = {if_g.S1, if_g.S2, if_g.S3, if_g.S4, if_g.S5};
      o.busy = if_g.busy; o.done = if_g.done; o.full = if_g.full; o.count = if_g.count;
    end else begin
      o.s = {if_z.S1, if_z.S2, if_z.S3, if_z.S4, if_z.S5};
      o.busy = if_z.busy; o.done = if_z.done; o.full = if_z.full; o.count = if_z.count;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_obs(input string nm, input int s, input int busy, input int done, input int count);
    obs_t o;
    o = get_obs();
    chk({nm, " s"}, int'(o.s), s);
    chk({nm, " busy"}, int'(o.busy), busy);
    chk({nm, " done"}, int'(o.done), done);
    chk({nm, " count"}, int'(o.count), count);
  endtask

  // Expected per-cycle stream is queued when play is driven and consumed cycle by cycle.
  task automatic run_replay(input string tag, input int n, input int gap,
                            input logic ld_play, input logic ld_during, input int exp_count);
    exp_t e;
    obs_t o;
    int   busy_cycles;
    busy_cycles = 0;
    for (int i = 0; i < n; i++) begin
      for (int h = 0; h < HOLD; h++) begin
        e.s = codes[i]; e.busy = 1'b1; e.done = 1'b0; exp_q.push_back(e);
      end
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          e.s = 5'd0; e.busy = 1'b1; e.done = 1'b0; exp_q.push_back(e);
        end
      end
    end
    e.s = 5'd0; e.busy = 1'b0; e.done = 1'b1; exp_q.push_back(e);
    e.s = 5'd0; e.busy = 1'b0; e.done = 1'b0; exp_q.push_back(e);
    pl = 1'b1; ld = ld_play; cd = 5'd5;
    tick();
    pl = 1'b0; ld = ld_during; cd = 5'd31;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = get_obs();
      if (o.busy) busy_cycles++;
      chk({tag, " s"}, int'(o.s), int'(e.s));
      chk({tag, " busy"}, int'(o.busy), int'(e.busy));
      chk({tag, " done"}, int'(o.done), int'(e.done));
      if (!e.busy) ld = 1'b0;
      tick();
    end
    ld = 1'b0;
    chk({tag, " busy_len"}, busy_cycles, n * HOLD + (n - 1) * gap);
    o = get_obs();
    chk({tag, " count_after"}, int'(o.count), exp_count);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    ld = 1'b0; pl = 1'b0; cl = 1'b0; cd = 5'd0; sel = 1'b0;

    //            ld  code   pl  cl  count full busy done s
    vecs[0] = '{1'b0, 5'd0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
    vecs[1] = '{1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
    vecs[2] = '{1'b1, 5'd1, 1'b0, 1'b0, 1, 0, 0, 0, 0};
    vecs[3] = '{1'b1, 5'd2, 1'b0, 1'b0, 2, 0, 0, 0, 0};
    vecs[4] = '{1'b1, 5'd3, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    vecs[5] = '{1'b1, 5'd4, 1'b0, 1'b0, 4, 1, 0, 0, 0};
    vecs[6] = '{1'b1, 5'd5, 1'b0, 1'b0, 4, 1, 0, 0, 0};
    vecs[7] = '{1'b0, 5'd0, 1'b0, 1'b0, 4, 1, 0, 0, 0};

    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      o = get_obs();
      chk_obs("reset", 0, 0, 0, 0);
      chk("reset full", int'(o.full), 0);
    end
    sel = 1'b0;
    rst_n = 1'b1;
    tick();

    // Asynchronous reset while the first code is being shown.
    ld = 1'b1; cd = 5'b10101; tick(); ld = 1'b0;
    pl = 1'b1; tick(); pl = 1'b0;
    chk_obs("rst_mid show1", 21, 1, 0, 1);
    tick();
    chk_obs("rst_mid show2", 21, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    chk_obs("rst_mid async", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    codes[0] = 5'b00011; codes[1] = 5'b01100; codes[2] = 5'b10001; codes[3] = 5'd0;
    for (int i = 0; i < 3; i++) begin
      ld = 1'b1; cd = codes[i]; tick(); ld = 1'b0;
      o = get_obs();
      chk("seq3 load count", int'(o.count), i + 1);
    end
    run_replay("seq3", 3, 1, 1'b0, 1'b0, 3);

    for (int v = 0; v < 8; v++) begin
      ld = vecs[v].ld; cd = vecs[v].cd; pl = vecs[v].pl; cl = vecs[v].cl;
      tick();
      ld = 1'b0; pl = 1'b0; cl = 1'b0;
      o = get_obs();
      chk($sformatf("vec%0d count", v), int'(o.count), vecs[v].count);
      chk($sformatf("vec%0d full", v), int'(o.full), vecs[v].full);
      chk($sformatf("vec%0d busy", v), int'(o.busy), vecs[v].busy);
      chk($sformatf("vec%0d done", v), int'(o.done), vecs[v].done);
      chk($sformatf("vec%0d s", v), int'(o.s), vecs[v].s);
    end

    codes[0] = 5'd1; codes[1] = 5'd2; codes[2] = 5'd3; codes[3] = 5'd4;
    run_replay("full4", 4, 1, 1'b0, 1'b1, 4);
    o = get_obs();
    chk("full4 full_after", int'(o.full), 1);

    // Clear on the second cycle of the second code.
    pl = 1'b1; tick(); pl = 1'b0;
    repeat (5) tick();
    chk_obs("clr show2c2", 2, 1, 0, 4);
    cl = 1'b1; tick(); cl = 1'b0;
    chk_obs("clr next", 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_obs("clr after", 0, 0, 0, 0);
    end
    pl = 1'b1; tick(); pl = 1'b0;
    chk_obs("clr play_empty", 0, 0, 0, 0);
    tick();
    chk_obs("clr play_empty2", 0, 0, 0, 0);

    sel = 1'b1;
    codes[0] = 5'd7; codes[1] = 5'd9;
    ld = 1'b1; cd = 5'd7; tick();
    cd = 5'd9; tick(); ld = 1'b0;
    chk_obs("gap0 loaded", 0, 0, 0, 2);
    run_replay("gap0a", 2, 0, 1'b0, 1'b0, 2);
    run_replay("gap0b", 2, 0, 1'b0, 1'b0, 2);
    run_replay("gap0lp", 2, 0, 1'b1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
